// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline hazard detection inputs and the front-end control outputs.
// The master drives the ID/EX status and receives the stall/flush controls and counters.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       ID_rs1;
  logic [4:0]       ID_rs2;
  logic             ID_uses_rs1;
  logic             ID_uses_rs2;
  logic             ID_EX_mem_read;
  logic [4:0]       ID_EX_rd;
  logic             branch_taken;
  logic             ext_stall_req;
  logic             cnt_clr;
  logic             pc_write;
  logic             pc_src;
  logic             IF_ID_write;
  logic             IF_flush;
  logic             ID_EX_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             hold_timeout;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_mem_read, ID_EX_rd,
    output branch_taken, ext_stall_req, cnt_clr,
    input  pc_write, pc_src, IF_ID_write, IF_flush, ID_EX_bubble,
    input  stall_cnt, flush_cnt, hold_timeout
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, ID_EX_mem_read, ID_EX_rd,
    input  branch_taken, ext_stall_req, cnt_clr,
    output pc_write, pc_src, IF_ID_write, IF_flush, ID_EX_bubble,
    output stall_cnt, flush_cnt, hold_timeout
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes and external freezes,
// with saturating stall/flush counters and a sticky watchdog on long freezes.
module hazard_control_unit #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input logic clk,
  input logic reset_n,
  hazard_control_unit_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_TIMEOUT < 1) ? 1 : $clog2(HOLD_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  typedef enum logic [1:0] {StRun, StLuStall, StHold} state_e;

  state_e             state_q, state_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               timeout_q, timeout_d;

  logic lu;
  logic pc_write, pc_src, if_id_write, if_flush, id_ex_bubble;

  assign lu = bus.ID_EX_mem_read && (bus.ID_EX_rd != 5'd0) &&
              ((bus.ID_uses_rs1 && (bus.ID_rs1 == bus.ID_EX_rd)) ||
               (bus.ID_uses_rs2 && (bus.ID_rs2 == bus.ID_EX_rd)));

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    pc_src       = 1'b0;
    if_flush     = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = StRun;
    unique case (state_q)
      // A HOLD cycle that samples ext_stall_req low is the exit cycle and already behaves as RUN.
      StRun, StHold: begin
        if (bus.ext_stall_req) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_d     = StHold;
        end else if (bus.branch_taken) begin
          pc_src   = 1'b1;
          if_flush = 1'b1;
        end else if (lu) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
          state_d      = StLuStall;
        end
      end
      // The bubble is already in EX, so lu is not re-evaluated here.
      StLuStall: begin
        if (bus.ext_stall_req) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          state_d     = StHold;
        end else if (bus.branch_taken) begin
          pc_src   = 1'b1;
          if_flush = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    hold_cnt_d = '0;
    if (state_d == StHold) begin
      hold_cnt_d = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
    end

    timeout_d = timeout_q | (hold_cnt_d == HoldMax);
    if (bus.cnt_clr) timeout_d = 1'b0;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!pc_write && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (if_flush && (flush_cnt_q != CntMax))  flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      hold_cnt_q  <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Controls are forced low for as long as reset is held.
  assign bus.pc_write     = reset_n & pc_write;
  assign bus.pc_src       = reset_n & pc_src;
  assign bus.IF_ID_write  = reset_n & if_id_write;
  assign bus.IF_flush     = reset_n & if_flush;
  assign bus.ID_EX_bubble = reset_n & id_ex_bubble;
  assign bus.stall_cnt    = stall_cnt_q;
  assign bus.flush_cnt    = flush_cnt_q;
  assign bus.hold_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit (CNT_W=4, HOLD_TIMEOUT=4): a per-cycle vector table
// followed by hand-written watchdog, saturation and asynchronous-reset sequences.
module tb_hazard_control_unit;

  localparam int unsigned CntW = 4;
  localparam logic [4:0] Def = 5'b10100;  // {pc_write, pc_src, IF_ID_write, IF_flush, ID_EX_bubble}
  localparam logic [4:0] Stl = 5'b00001;
  localparam logic [4:0] Flu = 5'b11110;
  localparam logic [4:0] Zer = 5'b00000;

  typedef struct {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic       br;
    logic       ext;
    logic       clr;
    logic [4:0] ctl;
    int         sc;
    int         fc;
  } vec_t;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;
  vec_t tbl[$];

  hazard_control_unit_if #(.CNT_W(CntW)) hif ();

  hazard_control_unit #(
    .CNT_W       (CntW),
    .HOLD_TIMEOUT(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic mr, logic [4:0] rd, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic br, logic ext, logic clr,
                              logic [4:0] ctl, int sc, int fc);
    vec_t v;
    v.mr = mr; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.br = br; v.ext = ext; v.clr = clr; v.ctl = ctl; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic drive(vec_t v);
    hif.ID_EX_mem_read = v.mr;
    hif.ID_EX_rd       = v.rd;
    hif.ID_rs1         = v.rs1;
    hif.ID_uses_rs1    = v.u1;
    hif.ID_rs2         = v.rs2;
    hif.ID_uses_rs2    = v.u2;
    hif.branch_taken   = v.br;
    hif.ext_stall_req  = v.ext;
    hif.cnt_clr        = v.clr;
  endtask

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic int ctl_now();
    return int'({hif.pc_write, hif.pc_src, hif.IF_ID_write, hif.IF_flush, hif.ID_EX_bubble});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t idle;
  vec_t v;

  initial begin
    n_vec = 0;
    n_err = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0);
    reset_n = 1'b0;
    drive(idle);

    //           mr rd rs1 u1 rs2 u2 br ext clr ctl  sc fc
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0));  // reset state
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 0, Stl, 0, 0));  // load-use on rs1
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 0, Def, 1, 0));  // LU_STALL ignores lu
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, Def, 1, 0));  // rd=0 never hazards
    tbl.push_back(mk(1, 7, 7, 0, 7, 1, 0, 0, 0, Stl, 1, 0));  // load-use on rs2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 2, 0));
    tbl.push_back(mk(1, 3, 3, 0, 0, 0, 0, 0, 0, Def, 2, 0));  // rs1 match but unused
    tbl.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 0, Def, 2, 0));  // not a load
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 1, 0, 0, Flu, 2, 0));  // branch beats lu
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, Def, 2, 1));  // cnt_clr
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, Zer, 0, 0));  // ext + branch, 3 cycles
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, Zer, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, Zer, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, Flu, 3, 0));  // branch taken on exit
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 3, 1));
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 1, 0, Zer, 3, 1));  // ext beats lu
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 1, 0, Zer, 4, 1));  // lu ignored in HOLD
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 5, 1));
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 0, Stl, 5, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, Zer, 6, 1));  // ext inside LU_STALL
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 7, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 7, 1));
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 1, Stl, 7, 1));  // clr beats stall increment
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0));
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 0, Stl, 0, 0));
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 1, 0, 0, Flu, 1, 0));  // branch inside LU_STALL
    tbl.push_back(mk(1, 5, 5, 1, 0, 0, 0, 0, 0, Stl, 1, 1));  // back in RUN, lu seen again
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 2, 1));

    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("ctl_in_reset", ctl_now(), 0);
    next_cycle();
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_ctl", i), ctl_now(), int'(tbl[i].ctl));
      chk($sformatf("v%0d_stall_cnt", i), int'(hif.stall_cnt), tbl[i].sc);
      chk($sformatf("v%0d_flush_cnt", i), int'(hif.flush_cnt), tbl[i].fc);
      chk($sformatf("v%0d_timeout", i), int'(hif.hold_timeout), 0);
      next_cycle();
    end

    // Watchdog: ext held 6 cycles, flag visible on the 4th HOLD cycle and sticky afterwards.
    v = idle;
    v.clr = 1'b1;
    drive(v);
    next_cycle();
    v = idle;
    v.ext = 1'b1;
    drive(v);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("wd_c%0d_ctl", c), ctl_now(), 0);
      if (c == 4) chk("wd_3rd_hold_timeout", int'(hif.hold_timeout), 0);
      if (c == 5) chk("wd_4th_hold_timeout", int'(hif.hold_timeout), 1);
      next_cycle();
    end
    drive(idle);
    @(negedge clk);
    chk("wd_exit_ctl", ctl_now(), int'(Def));
    chk("wd_exit_timeout", int'(hif.hold_timeout), 1);
    chk("wd_exit_stall_cnt", int'(hif.stall_cnt), 6);
    next_cycle();
    @(negedge clk);
    chk("wd_run_timeout", int'(hif.hold_timeout), 1);
    next_cycle();
    v = idle;
    v.clr = 1'b1;
    drive(v);
    next_cycle();
    drive(idle);
    @(negedge clk);
    chk("wd_clr_timeout", int'(hif.hold_timeout), 0);
    chk("wd_clr_stall_cnt", int'(hif.stall_cnt), 0);
    next_cycle();

    // 20 frozen cycles saturate the 4-bit stall counter, then reset mid-HOLD.
    v = idle;
    v.ext = 1'b1;
    drive(v);
    for (int c = 0; c < 20; c++) next_cycle();
    @(negedge clk);
    chk("sat_stall_cnt", int'(hif.stall_cnt), 15);
    chk("sat_ctl", ctl_now(), 0);
    chk("sat_timeout", int'(hif.hold_timeout), 1);
    drive(idle);
    reset_n = 1'b0;
    #1;
    chk("rst_ctl", ctl_now(), 0);
    chk("rst_stall_cnt", int'(hif.stall_cnt), 0);
    chk("rst_flush_cnt", int'(hif.flush_cnt), 0);
    chk("rst_timeout", int'(hif.hold_timeout), 0);
    next_cycle();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ctl", ctl_now(), int'(Def));
    chk("post_rst_stall_cnt", int'(hif.stall_cnt), 0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_ctl2", ctl_now(), int'(Def));
    chk("post_rst_stall_cnt2", int'(hif.stall_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL provide parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL provide parameter HOLD_TIMEOUT, default 255, the HOLD cycle count at which the watchdog fires.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; all flops SHALL use them.
REQ-004 clk  in  1  clock, rising edge.
REQ-005 reset_n  in  1  asynchronous reset, active low.
REQ-006 ID_rs1 / ID_rs2  in  5 each  source register indices of the instruction in ID.
REQ-007 ID_uses_rs1 / ID_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-008 ID_EX_mem_read  in  1  instruction in EX is a load.
REQ-009 ID_EX_rd  in  5  destination register of the instruction in EX.
REQ-010 branch_taken  in  1  branch resolved taken in ID this cycle.
REQ-011 ext_stall_req  in  1  memory or system request to freeze the front end.
REQ-012 cnt_clr  in  1  synchronous clear of the counters and the timeout flag.
REQ-013 pc_write  out  1  PC register update enable.
REQ-014 pc_src  out  1  select the branch target for the next PC.
REQ-015 IF_ID_write  out  1  IF/ID register update enable.
REQ-016 IF_flush  out  1  clear IF/ID to zero.
REQ-017 ID_EX_bubble  out  1  zero the ID/EX control fields (insert a NOP).
REQ-018 stall_cnt / flush_cnt  out  CNT_W each  performance counters.
REQ-019 hold_timeout  out  1  sticky watchdog flag.

Function
REQ-020 SHALL implement an FSM with states RUN, LU_STALL and HOLD; the control outputs (REQ-013..017) SHALL be combinational functions of state and inputs.
REQ-021 Load-use hazard (lu) SHALL be: ID_EX_mem_read and ID_EX_rd != 0 and ((ID_uses_rs1 and ID_rs1 == ID_EX_rd) or (ID_uses_rs2 and ID_rs2 == ID_EX_rd)).
REQ-022 RUN default outputs SHALL be pc_write=1, IF_ID_write=1, pc_src=0, IF_flush=0, ID_EX_bubble=0.
REQ-023 RUN priority SHALL be ext_stall_req > branch_taken > lu.
- ext_stall_req=1: all five control outputs 0; next state HOLD.
- branch_taken=1: pc_src=1, pc_write=1, IF_flush=1; stay in RUN.
- lu=1: pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next state LU_STALL.
REQ-024 LU_STALL SHALL last exactly one cycle and return to RUN; lu SHALL NOT be evaluated in it; ext_stall_req and branch_taken SHALL be handled exactly as in RUN (ext_stall_req -> HOLD).
REQ-025 In HOLD, all five control outputs SHALL be 0 and branch_taken and lu SHALL be ignored.
REQ-026 HOLD SHALL remain while ext_stall_req=1 and go to RUN on the first cycle it samples 0.
REQ-027 After HOLD exits, a still-asserted branch_taken SHALL be acted on in the first RUN cycle.
REQ-028 A hold counter SHALL count consecutive HOLD cycles, saturating at HOLD_TIMEOUT, and SHALL reset to 0 on leaving HOLD.
REQ-029 hold_timeout SHALL set on the cycle the hold counter reaches HOLD_TIMEOUT and stay set until cnt_clr or reset.
REQ-030 stall_cnt SHALL increment on each cycle with pc_write=0.
REQ-031 flush_cnt SHALL increment on each cycle with IF_flush=1.
REQ-032 stall_cnt and flush_cnt SHALL saturate at all-ones; there is no wrap-around.
REQ-033 cnt_clr SHALL take priority over any increment in the same cycle; the counters SHALL read 0 the next cycle.

Reset
REQ-034 While reset_n=0, all control outputs SHALL be 0.
REQ-035 Reset SHALL set state=RUN and hold counter, stall_cnt, flush_cnt and hold_timeout to 0.
REQ-036 Reset asserted mid-HOLD or mid-LU_STALL SHALL abort immediately; the first cycle after release SHALL be RUN with default outputs.

Verification
REQ-037 ID_EX_mem_read=1, ID_EX_rd=5, ID_rs1=5, ID_uses_rs1=1 -> that cycle pc_write=0, IF_ID_write=0, ID_EX_bubble=1; next cycle defaults; stall_cnt=1.
REQ-038 Same as REQ-037 but ID_EX_rd=0 -> no stall; stall_cnt stays 0.
REQ-039 branch_taken=1 together with lu=1 -> pc_src=1, IF_flush=1, pc_write=1, ID_EX_bubble=0; flush_cnt=1.
REQ-040 ext_stall_req=1 for 3 cycles with branch_taken=1 throughout -> 3 cycles of all-zero control outputs, then one cycle pc_src=1, IF_flush=1; stall_cnt=3.
REQ-041 HOLD_TIMEOUT=4, ext_stall_req held 6 cycles -> hold_timeout rises on the 4th HOLD cycle and stays 1 after exit until cnt_clr pulses.
REQ-042 CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturated); reset_n pulsed low during HOLD -> outputs 0 immediately, then RUN with all counters 0.
